// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PCSrc encodings, default vectors and the fetch FSM state type.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h8000_0180;

    localparam logic [2:0] PCSRC_SEQ = 3'b000;
    localparam logic [2:0] PCSRC_BR  = 3'b001;
    localparam logic [2:0] PCSRC_JR  = 3'b010;
    localparam logic [2:0] PCSRC_JMP = 3'b011;
    localparam logic [2:0] PCSRC_EXC = 3'b100;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_RESP = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

    // Encodings above PCSRC_EXC fall back to sequential fetch.
    function automatic logic is_redirect_src(input logic [2:0] src);
        return (src >= PCSRC_BR) && (src <= PCSRC_EXC);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC helper: sequential +4 and the redirect target mux.
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic [31:0] pc,
    input  logic [2:0]  pcsrc,
    input  logic [31:0] branch_target,
    input  logic [31:0] jr_target,
    input  logic [31:0] jump_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] target,
    output logic        redir_src
);

    assign pc_plus4  = pc + 32'd4;
    assign redir_src = is_redirect_src(pcsrc);

    always_comb begin
        target = pc_plus4;
        case (pcsrc)
            PCSRC_BR:  target = branch_target;
            PCSRC_JR:  target = jr_target;
            PCSRC_JMP: target = jump_target;
            PCSRC_EXC: target = EXC_VEC;
            default:   target = pc_plus4;
        endcase
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem handshake and IF/ID register.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  PCSrc,
    input  logic [31:0] branch_target,
    input  logic [31:0] jr_target,
    input  logic [31:0] jump_target,
    input  logic        PC_wen,
    input  logic        IF_wen,
    input  logic        IF_Flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PC_plus4,
    output logic        IF_ID_valid
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_plus4, target;
    logic         redir_src, redirect;
    logic [31:0]  hold_instr_q, hold_pc4_q;
    logic         hold_ld;
    logic         deliver;
    logic [31:0]  dlv_instr, dlv_pc4;

    pc_next_sel #(.EXC_VEC(EXC_VEC)) u_pc_next_sel (
        .pc            (pc_q),
        .pcsrc         (PCSrc),
        .branch_target (branch_target),
        .jr_target     (jr_target),
        .jump_target   (jump_target),
        .pc_plus4      (pc_plus4),
        .target        (target),
        .redir_src     (redir_src)
    );

    assign redirect  = PC_wen && redir_src;
    assign imem_addr = pc_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        imem_req  = 1'b0;
        hold_ld   = 1'b0;
        deliver   = 1'b0;
        dlv_instr = imem_rdata;
        dlv_pc4   = pc_plus4;
        case (state_q)
            ST_REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_d    = target;
                    state_d = imem_gnt ? ST_DROP : ST_REQ;
                end else if (imem_gnt) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (redirect) begin
                    // Response (now or later) belongs to the old path.
                    pc_d    = target;
                    state_d = imem_rvalid ? ST_REQ : ST_DROP;
                end else if (imem_rvalid) begin
                    if (IF_wen) begin
                        deliver = 1'b1;
                        if (PC_wen) pc_d = pc_plus4;
                        state_d = ST_REQ;
                    end else begin
                        hold_ld = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_DROP: begin
                if (redirect) pc_d = target;
                if (imem_rvalid) state_d = ST_REQ;
            end
            ST_HOLD: begin
                dlv_instr = hold_instr_q;
                dlv_pc4   = hold_pc4_q;
                if (redirect) begin
                    pc_d    = target;
                    state_d = ST_REQ;
                end else if (IF_wen) begin
                    deliver = 1'b1;
                    if (PC_wen) pc_d = pc_plus4;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            hold_instr_q <= 32'h0;
            hold_pc4_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (hold_ld) begin
                hold_instr_q <= imem_rdata;
                hold_pc4_q   <= pc_plus4;
            end
        end
    end

    // Flush beats stall; an enabled stage with nothing delivered takes a bubble.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            IF_ID_Instr    <= 32'h0;
            IF_ID_PC_plus4 <= 32'h0;
            IF_ID_valid    <= 1'b0;
        end else if (IF_Flush) begin
            IF_ID_Instr <= 32'h0;
            IF_ID_valid <= 1'b0;
        end else if (IF_wen) begin
            if (deliver) begin
                IF_ID_Instr    <= dlv_instr;
                IF_ID_PC_plus4 <= dlv_pc4;
                IF_ID_valid    <= 1'b1;
            end else begin
                IF_ID_Instr <= 32'h0;
                IF_ID_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: fetch stream, stall/hold, redirects, flush, wrap and reset.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  PCSrc;
    logic [31:0] branch_target, jr_target, jump_target;
    logic        PC_wen, IF_wen, IF_Flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_Instr, IF_ID_PC_plus4;
    logic        IF_ID_valid;

    int n_vec = 0;
    int n_err = 0;

    if_fetch_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .PCSrc          (PCSrc),
        .branch_target  (branch_target),
        .jr_target      (jr_target),
        .jump_target    (jump_target),
        .PC_wen         (PC_wen),
        .IF_wen         (IF_wen),
        .IF_Flush       (IF_Flush),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .IF_ID_Instr    (IF_ID_Instr),
        .IF_ID_PC_plus4 (IF_ID_PC_plus4),
        .IF_ID_valid    (IF_ID_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        PCSrc       = 3'b000;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4, input logic v);
        chk({tag, ".instr"}, IF_ID_Instr, ins);
        chk({tag, ".pc4"},   IF_ID_PC_plus4, p4);
        chk({tag, ".valid"}, {31'h0, IF_ID_valid}, {31'h0, v});
    endtask

    task automatic chk_bus(input string tag, input logic rq, input logic [31:0] a);
        chk({tag, ".req"},  {31'h0, imem_req}, {31'h0, rq});
        chk({tag, ".addr"}, imem_addr, a);
    endtask

    initial begin
        reset_n = 1'b0;
        branch_target = 32'h0; jr_target = 32'h0; jump_target = 32'h0;
        PC_wen = 1'b1; IF_wen = 1'b1; IF_Flush = 1'b0;
        idle_bus();

        // reset state
        tick(); tick();
        chk_ifid("rst", 32'h0, 32'h0, 1'b0);
        chk_bus("rst", 1'b1, 32'h0040_0000);
        reset_n = 1'b1;

        // sequential stream: gnt cycle then rvalid cycle, rdata = addr
        for (int i = 0; i < 3; i++) begin
            imem_gnt = 1'b1; imem_rvalid = 1'b0;
            tick();
            chk_bus("seq.resp", 1'b0, 32'h0040_0000 + 32'(4 * i));
            chk("seq.bubble", {31'h0, IF_ID_valid}, 32'h0);
            imem_rvalid = 1'b1; imem_rdata = 32'h0040_0000 + 32'(4 * i);
            tick();
            chk_ifid("seq.dlv", 32'h0040_0000 + 32'(4 * i), 32'h0040_0004 + 32'(4 * i), 1'b1);
            chk_bus("seq.next", 1'b1, 32'h0040_0004 + 32'(4 * i));
        end

        // stall while response arrives -> HOLD, IF/ID frozen
        imem_gnt = 1'b1; imem_rvalid = 1'b0;
        tick();
        chk_ifid("hold.pre", 32'h0, 32'h0040_000C, 1'b0);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_000C;
        IF_wen = 1'b0; PC_wen = 1'b0;
        tick();
        imem_rvalid = 1'b0;
        tick(); tick();
        chk_ifid("hold.frozen", 32'h0, 32'h0040_000C, 1'b0);
        chk_bus("hold.bus", 1'b0, 32'h0040_000C);
        IF_wen = 1'b1; PC_wen = 1'b1;
        tick();
        chk_ifid("hold.rel", 32'hCAFE_000C, 32'h0040_0010, 1'b1);
        chk_bus("hold.next", 1'b1, 32'h0040_0010);

        // branch in RESP with rvalid: word discarded
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0010;
        PCSrc = 3'b001; branch_target = 32'h0040_0100;
        tick();
        idle_bus();
        chk("br.valid", {31'h0, IF_ID_valid}, 32'h0);
        chk_bus("br.next", 1'b1, 32'h0040_0100);

        // jump coincident with gnt -> DROP, stale rvalid swallowed
        imem_gnt = 1'b1; PCSrc = 3'b011; jump_target = 32'h0040_0200;
        tick();
        idle_bus();
        chk_bus("drop.bus", 1'b0, 32'h0040_0200);
        tick();
        chk_bus("drop.wait", 1'b0, 32'h0040_0200);
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        idle_bus();
        chk("drop.valid", {31'h0, IF_ID_valid}, 32'h0);
        chk_bus("drop.next", 1'b1, 32'h0040_0200);

        // redirect without gnt; low target bits pass through
        PCSrc = 3'b010; jr_target = 32'h0040_0303;
        tick();
        chk_bus("jr", 1'b1, 32'h0040_0303);
        // redirect ignored when PC_wen=0
        PC_wen = 1'b0; jr_target = 32'h1234_5678;
        tick();
        PC_wen = 1'b1;
        chk_bus("jr.nowen", 1'b1, 32'h0040_0303);

        // wrap from FFFFFFFC to 0
        jr_target = 32'hFFFF_FFFC;
        tick();
        idle_bus();
        chk_bus("wrap.addr", 1'b1, 32'hFFFF_FFFC);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
        tick();
        idle_bus();
        chk_ifid("wrap.dlv", 32'h3333_3333, 32'h0, 1'b1);
        chk_bus("wrap.next", 1'b1, 32'h0);

        // exception vector; PCSrc=101 behaves as sequential (no move in REQ)
        PCSrc = 3'b100;
        tick();
        chk_bus("exc", 1'b1, 32'h8000_0180);
        PCSrc = 3'b101;
        tick();
        chk_bus("src5", 1'b1, 32'h8000_0180);
        PCSrc = 3'b000;

        // flush with IF_wen=0 still clears the instruction
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222;
        tick();
        idle_bus();
        chk_ifid("fl.pre", 32'h1111_2222, 32'h8000_0184, 1'b1);
        IF_Flush = 1'b1; IF_wen = 1'b0;
        tick();
        IF_Flush = 1'b0; IF_wen = 1'b1;
        chk_ifid("fl.post", 32'h0, 32'h8000_0184, 1'b0);

        // reset while in RESP; stale rvalid afterwards is not delivered
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk_bus("rr.resp", 1'b0, 32'h8000_0184);
        reset_n = 1'b0;
        tick();
        chk_ifid("rr.rst", 32'h0, 32'h0, 1'b0);
        chk_bus("rr.rst", 1'b1, 32'h0040_0000);
        reset_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD1_BAD1;
        tick();
        idle_bus();
        chk_ifid("rr.stale", 32'h0, 32'h0, 1'b0);
        chk_bus("rr.stale", 1'b1, 32'h0040_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
